// File: rtl/ksa_pipe_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder/subtractor.
package ksa_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  localparam logic KSA_ADD = 1'b0;
  localparam logic KSA_SUB = 1'b1;

  // Rank 0 plus one rank per group of prefix levels (the last group ends in the output rank).
  function automatic int ksa_nranks(input int width, input int lps);
    int l2;
    l2 = $clog2(width);
    return 1 + (l2 + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for ksa_pipe.
interface ksa_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone prefix level combining each bit with the bit DIST below it.
module ksa_prefix_level
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  pg_t [WIDTH-1:0] prev,
  output pg_t [WIDTH-1:0] next
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_comb
      assign next[i].g = prev[i].g | (prev[i].p & prev[i-DIST].g);
      assign next[i].p = prev[i].p & prev[i-DIST].p;
    end else begin : g_pass
      assign next[i] = prev[i];
    end
  end

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with global-stall valid/ready flow control.
module ksa_pipe
  import ksa_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input logic      clk,
  input logic      rst_n,
  ksa_pipe_if.slave bus
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int NR    = ksa_nranks(WIDTH, LEVELS_PER_STAGE);
  localparam int NMID  = NR - 1;

  logic adv;
  logic out_valid_q;

  assign adv          = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = adv;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] praw;
  logic             c0;
  pg_t  [WIDTH-1:0] pg0;

  always_comb begin
    b_eff = bus.in_b ^ {WIDTH{bus.in_sub}};
    c0    = (bus.in_sub == KSA_SUB) ? 1'b1 : bus.in_cin;
    praw  = bus.in_a ^ b_eff;
    pg0   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pg0[i].p = praw[i];
      pg0[i].g = bus.in_a[i] & b_eff[i];
    end
    pg0[0].g = pg0[0].g | (pg0[0].p & c0);
  end

  // lv[k] is the output of prefix level k; st[k] feeds level k+1 (registered at rank boundaries).
  pg_t [LOG2W:0][WIDTH-1:0]   lv;
  pg_t [LOG2W-1:0][WIDTH-1:0] st;

  logic [NMID-1:0][WIDTH-1:0] sd_p;
  logic [NMID-1:0]            sd_c0;
  logic [NMID-1:0]            sd_v;
  logic [NMID-1:0][TAG_W-1:0] sd_tag;

  assign lv[0] = pg0;

  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    if (k % LEVELS_PER_STAGE == 0) begin : g_rank
      localparam int R = k / LEVELS_PER_STAGE;

      logic [WIDTH-1:0] d_p;
      logic             d_c0;
      logic             d_v;
      logic [TAG_W-1:0] d_tag;

      pg_t  [WIDTH-1:0] q_pg;
      logic [WIDTH-1:0] q_p;
      logic             q_c0;
      logic             q_v;
      logic [TAG_W-1:0] q_tag;

      if (R == 0) begin : g_first
        assign d_p   = praw;
        assign d_c0  = c0;
        assign d_v   = bus.in_valid;
        assign d_tag = bus.in_tag;
      end else begin : g_next
        assign d_p   = sd_p[R-1];
        assign d_c0  = sd_c0[R-1];
        assign d_v   = sd_v[R-1];
        assign d_tag = sd_tag[R-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_pg  <= '0;
          q_p   <= '0;
          q_c0  <= 1'b0;
          q_v   <= 1'b0;
          q_tag <= '0;
        end else if (adv) begin
          q_pg  <= lv[k];
          q_p   <= d_p;
          q_c0  <= d_c0;
          q_v   <= d_v;
          q_tag <= d_tag;
        end
      end

      assign st[k]     = q_pg;
      assign sd_p[R]   = q_p;
      assign sd_c0[R]  = q_c0;
      assign sd_v[R]   = q_v;
      assign sd_tag[R] = q_tag;
    end else begin : g_wire
      assign st[k] = lv[k];
    end

    ksa_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_lvl (
      .prev (st[k]),
      .next (lv[k+1])
    );
  end

  logic [WIDTH-1:0] gfin;
  logic [WIDTH-1:0] pfin;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             unused_pfin;

  always_comb begin
    gfin = '0;
    pfin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gfin[i] = lv[LOG2W][i].g;
      pfin[i] = lv[LOG2W][i].p;
    end
    carry = {gfin[WIDTH-2:0], sd_c0[NMID-1]};
    sum   = sd_p[NMID-1] ^ carry;
    cout  = gfin[WIDTH-1];
    ovf   = carry[WIDTH-1] ^ cout;
  end

  // Group propagate of the last level is only needed inside the tree.
  assign unused_pfin = ^pfin;

  logic [WIDTH-1:0] out_sum_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (adv) begin
      out_valid_q <= sd_v[NMID-1];
      out_sum_q   <= sum;
      out_cout_q  <= cout;
      out_ovf_q   <= ovf;
      out_tag_q   <= sd_tag[NMID-1];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_ksa_pipe.sv
// Scoreboard bench for ksa_pipe: 16-bit/2-level-per-stage instance and 5-bit/1-level-per-stage instance.
module tb_ksa_pipe;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ksa_pipe_if #(.WIDTH(16), .TAG_W(4)) bus16 ();
  ksa_pipe_if #(.WIDTH(5),  .TAG_W(4)) bus5 ();

  ksa_pipe #(.WIDTH(16), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  ksa_pipe #(.WIDTH(5), .LEVELS_PER_STAGE(1), .TAG_W(4)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
  } exp_t;

  exp_t q16[$];
  exp_t q5[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: a + b' + c0 evaluated in wide integer arithmetic.
  function automatic void model(input int w, input int unsigned a, input int unsigned b,
                                input bit cin, input bit sub,
                                output int unsigned sum, output bit cout, output bit ovf);
    int unsigned mask, bb, c0, full;
    mask = (32'd1 << w) - 1;
    bb   = sub ? (~b & mask) : (b & mask);
    c0   = sub ? 1 : {31'd0, cin};
    full = (a & mask) + bb + c0;
    sum  = full & mask;
    cout = ((full >> w) & 1) != 0;
    ovf  = (((a >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
           (((sum >> (w-1)) & 1) != ((a >> (w-1)) & 1));
  endfunction

  // Present one op on bus16 until accepted; the expected result is queued on acceptance.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [3:0] tag,
                        input logic [15:0] esum, input logic ecout, input logic eovf);
    exp_t e;
    bit   acc;
    acc = 0;
    bus16.in_a = a; bus16.in_b = b; bus16.in_cin = cin; bus16.in_sub = sub;
    bus16.in_tag = tag; bus16.in_valid = 1'b1;
    e.sum = esum; e.cout = ecout; e.ovf = eovf; e.tag = tag;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (bus16.in_ready) begin
        q16.push_back(e);
        acc = 1;
      end
      @(posedge clk);
      #1;
    end
    bus16.in_valid = 1'b0;
    if (!acc) chk("send16_timeout", 32'd0, 32'd1);
  endtask

  task automatic send16_model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                              input logic sub, input logic [3:0] tag);
    int unsigned s;
    bit co, ov;
    model(16, a, b, cin, sub, s, co, ov);
    send16(a, b, cin, sub, tag, s[15:0], co, ov);
  endtask

  task automatic send5_model(input logic [4:0] a, input logic [4:0] b, input logic cin,
                             input logic sub, input logic [3:0] tag);
    int unsigned s;
    bit   co, ov, acc;
    exp_t e;
    model(5, a, b, cin, sub, s, co, ov);
    e.sum = s[15:0]; e.cout = co; e.ovf = ov; e.tag = tag;
    acc = 0;
    bus5.in_a = a; bus5.in_b = b; bus5.in_cin = cin; bus5.in_sub = sub;
    bus5.in_tag = tag; bus5.in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (bus5.in_ready) begin
        q5.push_back(e);
        acc = 1;
      end
      @(posedge clk);
      #1;
    end
    bus5.in_valid = 1'b0;
    if (!acc) chk("send5_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain16();
    for (int k = 0; k < 50 && q16.size() > 0; k++) @(negedge clk);
    chk("drain16_empty", q16.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain5();
    for (int k = 0; k < 50 && q5.size() > 0; k++) @(negedge clk);
    chk("drain5_empty", q5.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitors: pop on each completed handshake and compare.
  logic        stall_prev = 1'b0;
  logic [15:0] held_sum;
  logic [3:0]  held_tag;
  logic        held_cout, held_ovf;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_valid", bus16.out_valid, 1'b1);
        chk("stall_hold_sum", bus16.out_sum, held_sum);
        chk("stall_hold_tag", bus16.out_tag, held_tag);
        chk("stall_hold_flags", {bus16.out_cout, bus16.out_ovf}, {held_cout, held_ovf});
      end
      stall_prev = bus16.out_valid & ~bus16.out_ready;
      held_sum = bus16.out_sum; held_tag = bus16.out_tag;
      held_cout = bus16.out_cout; held_ovf = bus16.out_ovf;
      if (bus16.out_valid && bus16.out_ready) begin
        chk("m16_unexpected", q16.size() > 0, 1'b1);
        if (q16.size() > 0) begin
          e = q16.pop_front();
          chk("m16_tag", bus16.out_tag, e.tag);
          chk("m16_sum", bus16.out_sum, e.sum);
          chk("m16_cout", bus16.out_cout, e.cout);
          chk("m16_ovf", bus16.out_ovf, e.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus5.out_valid && bus5.out_ready) begin
      chk("m5_unexpected", q5.size() > 0, 1'b1);
      if (q5.size() > 0) begin
        e = q5.pop_front();
        chk("m5_tag", bus5.out_tag, e.tag);
        chk("m5_sum", bus5.out_sum, e.sum);
        chk("m5_cout", bus5.out_cout, e.cout);
        chk("m5_ovf", bus5.out_ovf, e.ovf);
      end
    end
  end

  initial begin
    int lat;
    int idx;
    int nstall;

    rst_n = 1'b0;
    bus16.in_valid = 0; bus16.in_a = 0; bus16.in_b = 0; bus16.in_cin = 0;
    bus16.in_sub = 0; bus16.in_tag = 0; bus16.out_ready = 1;
    bus5.in_valid = 0; bus5.in_a = 0; bus5.in_b = 0; bus5.in_cin = 0;
    bus5.in_sub = 0; bus5.in_tag = 0; bus5.out_ready = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus16.out_valid, 0);
    chk("rst_out_sum", bus16.out_sum, 16'h0000);
    chk("rst_out_tag", bus16.out_tag, 0);
    chk("rst_out_flags", {bus16.out_cout, bus16.out_ovf}, 2'b00);
    chk("rst_in_ready", bus16.in_ready, 1);
    chk("rst5_out_valid", bus5.out_valid, 0);
    chk("rst5_in_ready", bus5.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus16.in_ready, 1);

    // Wrap, with latency measured from the accepting edge.
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus16.out_valid && lat < 20);
    chk("latency16", lat, 3);
    @(posedge clk);
    #1;
    drain16();

    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd2, 16'h8000, 1'b0, 1'b1);
    send16(16'h0005, 16'h0007, 1'b1, 1'b1, 4'd3, 16'hFFFE, 1'b0, 1'b0);
    send16(16'h8000, 16'h0001, 1'b0, 1'b1, 4'd4, 16'h7FFF, 1'b1, 1'b1);
    drain16();

    // Backpressure: 8 back-to-back ops, output stalled for 3 cycles mid-stream.
    idx = 0;
    nstall = 0;
    for (int c = 0; c < 40 && (idx < 8 || q16.size() > 0); c++) begin
      bus16.out_ready = !(c >= 4 && c < 7);
      if (idx < 8) begin
        bus16.in_valid = 1'b1;
        bus16.in_a = 16'h1234 * idx[15:0] + 16'h0F00;
        bus16.in_b = 16'h0F0F ^ idx[15:0];
        bus16.in_cin = idx[0];
        bus16.in_sub = idx[1];
        bus16.in_tag = idx[3:0];
      end else begin
        bus16.in_valid = 1'b0;
      end
      @(negedge clk);
      if (!bus16.out_ready && bus16.out_valid) begin
        chk("stall_in_ready", bus16.in_ready, 0);
        nstall++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        int unsigned s;
        bit co, ov;
        exp_t e;
        model(16, bus16.in_a, bus16.in_b, bus16.in_cin, bus16.in_sub, s, co, ov);
        e.sum = s[15:0]; e.cout = co; e.ovf = ov; e.tag = bus16.in_tag;
        q16.push_back(e);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    chk("bp_sent", idx, 8);
    chk("bp_stall_cycles", nstall, 3);
    chk("bp_drained", q16.size(), 0);

    // Reset with three ops in flight: nothing may emerge afterwards.
    send16_model(16'h1111, 16'h2222, 1'b0, 1'b0, 4'd8);
    send16_model(16'h3333, 16'h0444, 1'b1, 1'b0, 4'd9);
    send16_model(16'hA000, 16'h0001, 1'b0, 1'b1, 4'd10);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus16.out_valid, 0);
    chk("midrst_out_sum", bus16.out_sum, 16'h0000);
    chk("midrst_in_ready", bus16.in_ready, 1);
    q16.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_midrst_quiet", bus16.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Non-power-of-two width: latency then 1000 random ops.
    send5_model(5'd31, 5'd1, 1'b0, 1'b0, 4'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus5.out_valid && lat < 20);
    chk("latency5", lat, 4);
    @(posedge clk);
    #1;
    drain5();
    for (int n = 0; n < 1000; n++) begin
      send5_model(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(n));
    end
    drain5();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
